hough_line_param: RTL and testbench
===================================

Name: hough_line_param

Overview:
Sits directly upstream of div_signed and also consumes its quotient. Takes Hough accumulator peaks (rho, theta index) from the peak-pick stage and looks up sin/cos. It sequences two signed divisions through one shared div_signed instance: slope = -cos/sin and intercept = rho/sin. It then presents the line parameters to the lane-drawing stage with a valid/ready handshake.

Parameters:
RHO_WIDTH, 11, signed rho width in pixels
THETA_WIDTH, 8, unsigned theta index width, 1 degree per step, legal range 0..179
TRIG_FRAC, 10, fractional bits of the trig LUT values; 1.0 = 1024
SLOPE_FRAC, 8, fractional bits of the slope output
DIVIDEND_WIDTH, 24, width of the divider dividend and quotient
DIVISOR_WIDTH, 12, width of the divider divisor and trig values (signed Q1.10)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  peak valid
in_ready  out  1  block can accept a peak
in_rho  in  RHO_WIDTH  signed rho
in_theta  in  THETA_WIDTH  theta index
div_valid_in  out  1  one-cycle request pulse to div_signed
div_dividend  out  DIVIDEND_WIDTH  signed dividend
div_divisor  out  DIVISOR_WIDTH  signed divisor
div_quotient  in  DIVIDEND_WIDTH  signed quotient; sampled only when div_valid_out=1
div_valid_out  in  1  one-cycle result pulse from div_signed
out_valid  out  1  line parameters valid
out_ready  in  1  downstream accepts
out_slope  out  DIVIDEND_WIDTH  signed, SLOPE_FRAC fractional bits
out_intercept  out  DIVIDEND_WIDTH  signed integer pixels; y-intercept, or x-intercept when vertical
out_vertical  out  1  line is vertical (sin = 0)

Behaviour:
- Reset: state IDLE. in_ready=1, out_valid=0, div_valid_in=0; out_slope, out_intercept, out_vertical, div_dividend, div_divisor all 0. Reset mid-operation abandons the peak; div_signed shares the same reset.
- Clock/reset: one clock (clk). Reset is synchronous and active-high.
- FSM states: IDLE, ISSUE_M, WAIT_M, ISSUE_C, WAIT_C, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid, register rho. Register theta, clamped to 179 if above 179. Go to ISSUE_M.
  - The LUT read is registered, so trig values are available in ISSUE_M.
- ISSUE_M:
  - If sin == 0: out_vertical=1, out_slope = all-ones positive max (0x7FFFFF), out_intercept = sign-extended rho. Go to OUT; no division is issued.
  - Else: pulse div_valid_in for exactly 1 cycle with dividend = -(cos sign-extended) << SLOPE_FRAC and divisor = sin. Go to WAIT_M.
- WAIT_M: dividend and divisor are held stable. On div_valid_out, capture out_slope = div_quotient and go to ISSUE_C.
- ISSUE_C: pulse div_valid_in with dividend = (rho sign-extended) << TRIG_FRAC and divisor = sin. Go to WAIT_C.
- WAIT_C: on div_valid_out, capture out_intercept and go to OUT.
- Divider latency is variable. The block never issues a request while one is outstanding. div_valid_out in any state other than WAIT_M/WAIT_C is ignored.
- OUT:
  - out_valid=1; outputs are stable until out_ready.
  - On out_valid && out_ready, go to IDLE and clear out_vertical.
  - in_ready=0 in every state except IDLE, so there is 1 peak in flight.
- Arithmetic: all sign-extended to DIVIDEND_WIDTH before the shift. Quotients truncate toward zero, as div_signed does.
- Throughput: minimum 1 + 1 + (divider latency + 1) × 2 + 1 cycles per non-vertical peak.

Decomposition:
- Package hough_pkg: TRIG_FRAC, SLOPE_FRAC, THETA_MAX=179, the 180-entry sin/cos constant arrays (round(1024·sin/cos)), and the state_t enum.
- Sub-module hough_trig_lut: registered ROM, theta index in, signed sin and cos out, 1-cycle latency.
- div_signed is instantiated by the parent, not inside this block.

Test Plan:
- rho=100, theta=90 (sin=1024, cos=0) -> slope 0, intercept 100, vertical 0; exactly 2 div_valid_in pulses.
- rho=100, theta=45 (sin=cos=724) -> slope -256, intercept 141 (102400/724 truncated).
- rho=-50, theta=135 (cos=-724, sin=724) -> slope +256, intercept -70 (-51200/724 truncated toward zero).
- rho=37, theta=0 -> vertical 1, slope 0x7FFFFF, intercept 37; zero div_valid_in pulses; out_valid 2 cycles after acceptance.
- Backpressure: out_ready held low 10 cycles -> outputs stable, in_ready 0. A second in_valid peak is accepted only after the handshake. theta=200 -> processed as theta 179.
- Reset asserted during WAIT_C -> next cycle in_ready=1, out_valid=0. A fresh peak (rho=100, theta=90) then completes correctly.

Source files
------------

// File: rtl/hough_pkg.sv
// hough_pkg: shared constants, trig tables (round(1024*sin/cos)) and FSM state type for the Hough line stage.
package hough_pkg;
    localparam int TRIG_FRAC  = 10;
    localparam int SLOPE_FRAC = 8;
    localparam int THETA_MAX  = 179;
    typedef enum logic [2:0] {IDLE, ISSUE_M, WAIT_M, ISSUE_C, WAIT_C, OUT} state_t;
    localparam int SIN_LUT [180] = '{
        0, 18, 36, 54, 71, 89, 107, 125, 143, 160, 178, 195,
        213, 230, 248, 265, 282, 299, 316, 333, 350, 367, 384, 400,
        416, 433, 449, 465, 481, 496, 512, 527, 543, 558, 573, 587,
        602, 616, 630, 644, 658, 672, 685, 698, 711, 724, 737, 749,
        761, 773, 784, 796, 807, 818, 828, 839, 849, 859, 868, 878,
        887, 896, 904, 912, 920, 928, 935, 943, 949, 956, 962, 968,
        974, 979, 984, 989, 994, 998, 1002, 1005, 1008, 1011, 1014, 1016,
        1018, 1020, 1022, 1023, 1023, 1024, 1024, 1024, 1023, 1023, 1022, 1020,
        1018, 1016, 1014, 1011, 1008, 1005, 1002, 998, 994, 989, 984, 979,
        974, 968, 962, 956, 949, 943, 935, 928, 920, 912, 904, 896,
        887, 878, 868, 859, 849, 839, 828, 818, 807, 796, 784, 773,
        761, 749, 737, 724, 711, 698, 685, 672, 658, 644, 630, 616,
        602, 587, 573, 558, 543, 527, 512, 496, 481, 465, 449, 433,
        416, 400, 384, 367, 350, 333, 316, 299, 282, 265, 248, 230,
        213, 195, 178, 160, 143, 125, 107, 89, 71, 54, 36, 18
    };
    localparam int COS_LUT [180] = '{
        1024, 1024, 1023, 1023, 1022, 1020, 1018, 1016, 1014, 1011, 1008, 1005,
        1002, 998, 994, 989, 984, 979, 974, 968, 962, 956, 949, 943,
        935, 928, 920, 912, 904, 896, 887, 878, 868, 859, 849, 839,
        828, 818, 807, 796, 784, 773, 761, 749, 737, 724, 711, 698,
        685, 672, 658, 644, 630, 616, 602, 587, 573, 558, 543, 527,
        512, 496, 481, 465, 449, 433, 416, 400, 384, 367, 350, 333,
        316, 299, 282, 265, 248, 230, 213, 195, 178, 160, 143, 125,
        107, 89, 71, 54, 36, 18, 0, -18, -36, -54, -71, -89,
        -107, -125, -143, -160, -178, -195, -213, -230, -248, -265, -282, -299,
        -316, -333, -350, -367, -384, -400, -416, -433, -449, -465, -481, -496,
        -512, -527, -543, -558, -573, -587, -602, -616, -630, -644, -658, -672,
        -685, -698, -711, -724, -737, -749, -761, -773, -784, -796, -807, -818,
        -828, -839, -849, -859, -868, -878, -887, -896, -904, -912, -920, -928,
        -935, -943, -949, -956, -962, -968, -974, -979, -984, -989, -994, -998,
        -1002, -1005, -1008, -1011, -1014, -1016, -1018, -1020, -1022, -1023, -1023, -1024
    };
endpackage

// File: rtl/hough_trig_lut.sv
// hough_trig_lut: registered sin/cos ROM, loads on en, one cycle of latency.
module hough_trig_lut
    import hough_pkg::*;
#(
    parameter int THETA_WIDTH   = 8,
    parameter int DIVISOR_WIDTH = 12
) (
    input  logic                            clk,
    input  logic                            en,
    input  logic [THETA_WIDTH-1:0]          theta,
    output logic signed [DIVISOR_WIDTH-1:0] sin_val,
    output logic signed [DIVISOR_WIDTH-1:0] cos_val
);
    logic signed [DIVISOR_WIDTH-1:0] sin_q, sin_d, cos_q, cos_d;
    always_comb begin
        sin_d = en ? DIVISOR_WIDTH'(SIN_LUT[theta]) : sin_q;
        cos_d = en ? DIVISOR_WIDTH'(COS_LUT[theta]) : cos_q;
    end
    always_ff @(posedge clk) begin
        sin_q <= sin_d;
        cos_q <= cos_d;
    end
    assign sin_val = sin_q;
    assign cos_val = cos_q;
endmodule

// File: rtl/hough_line_param.sv
// hough_line_param: turns a (rho, theta) peak into slope/intercept using a shared external signed divider.
module hough_line_param
    import hough_pkg::*;
#(
    parameter int RHO_WIDTH      = 11,
    parameter int THETA_WIDTH    = 8,
    parameter int DIVIDEND_WIDTH = 24,
    parameter int DIVISOR_WIDTH  = 12
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [RHO_WIDTH-1:0]      in_rho,
    input  logic [THETA_WIDTH-1:0]           in_theta,
    output logic                             div_valid_in,
    output logic signed [DIVIDEND_WIDTH-1:0] div_dividend,
    output logic signed [DIVISOR_WIDTH-1:0]  div_divisor,
    input  logic signed [DIVIDEND_WIDTH-1:0] div_quotient,
    input  logic                             div_valid_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic signed [DIVIDEND_WIDTH-1:0] out_slope,
    output logic signed [DIVIDEND_WIDTH-1:0] out_intercept,
    output logic                             out_vertical
);
    state_t                           state_q, state_d;
    logic signed [RHO_WIDTH-1:0]      rho_q, rho_d;
    logic signed [DIVIDEND_WIDTH-1:0] slope_q, slope_d, intercept_q, intercept_d, dividend_q, dividend_d;
    logic signed [DIVISOR_WIDTH-1:0]  divisor_q, divisor_d, sin_val, cos_val;
    logic                             vertical_q, vertical_d, div_valid_q, div_valid_d;
    logic                             accept;
    logic [THETA_WIDTH-1:0]           theta_clamp;
    assign accept      = (state_q == IDLE) && in_valid;
    assign theta_clamp = (in_theta > THETA_WIDTH'(THETA_MAX)) ? THETA_WIDTH'(THETA_MAX) : in_theta;
    // LUT register doubles as the theta register, so trig is ready in ISSUE_M
    hough_trig_lut #(.THETA_WIDTH(THETA_WIDTH), .DIVISOR_WIDTH(DIVISOR_WIDTH)) u_lut (
        .clk     (clk),
        .en      (accept),
        .theta   (theta_clamp),
        .sin_val (sin_val),
        .cos_val (cos_val)
    );
    always_comb begin
        state_d     = state_q;
        rho_d       = rho_q;
        slope_d     = slope_q;
        intercept_d = intercept_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        vertical_d  = vertical_q;
        div_valid_d = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                rho_d   = in_rho;
                state_d = ISSUE_M;
            end
            ISSUE_M: if (sin_val == '0) begin
                vertical_d  = 1'b1;
                slope_d     = {1'b0, {(DIVIDEND_WIDTH-1){1'b1}}};
                intercept_d = DIVIDEND_WIDTH'(rho_q);
                state_d     = OUT;
            end else begin
                div_valid_d = 1'b1;
                dividend_d  = (-DIVIDEND_WIDTH'(cos_val)) << SLOPE_FRAC;
                divisor_d   = sin_val;
                state_d     = WAIT_M;
            end
            WAIT_M: if (div_valid_out) begin
                slope_d = div_quotient;
                state_d = ISSUE_C;
            end
            ISSUE_C: begin
                div_valid_d = 1'b1;
                dividend_d  = DIVIDEND_WIDTH'(rho_q) << TRIG_FRAC;
                divisor_d   = sin_val;
                state_d     = WAIT_C;
            end
            WAIT_C: if (div_valid_out) begin
                intercept_d = div_quotient;
                state_d     = OUT;
            end
            OUT: if (out_ready) begin
                vertical_d = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rho_q       <= '0;
            slope_q     <= '0;
            intercept_q <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            vertical_q  <= 1'b0;
            div_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rho_q       <= rho_d;
            slope_q     <= slope_d;
            intercept_q <= intercept_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            vertical_q  <= vertical_d;
            div_valid_q <= div_valid_d;
        end
    end
    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == OUT);
    assign div_valid_in  = div_valid_q;
    assign div_dividend  = dividend_q;
    assign div_divisor   = divisor_q;
    assign out_slope     = slope_q;
    assign out_intercept = intercept_q;
    assign out_vertical  = vertical_q;
endmodule

// File: tb/tb_hough_line_param.sv
// tb_hough_line_param: directed vectors against hand-computed line parameters, with a variable-latency divider model.
module tb_hough_line_param;
    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid, in_ready;
    logic signed [10:0] in_rho;
    logic [7:0]         in_theta;
    logic               div_valid_in;
    logic signed [23:0] div_dividend;
    logic signed [11:0] div_divisor;
    logic signed [23:0] div_quotient = '0;
    logic               div_valid_out = 1'b0;
    logic               out_valid, out_ready;
    logic signed [23:0] out_slope, out_intercept;
    logic               out_vertical;
    int                 n_chk = 0, n_pass = 0;
    int                 div_lat = 3, pulses = 0, cnt = 0, cyc = 0, p0 = 0;
    logic               overlap = 1'b0;
    logic signed [23:0] q_hold = '0;
    always #5 clk = ~clk;
    hough_line_param dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rho        (in_rho),
        .in_theta      (in_theta),
        .div_valid_in  (div_valid_in),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_valid_out (div_valid_out),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_slope     (out_slope),
        .out_intercept (out_intercept),
        .out_vertical  (out_vertical)
    );
    // divider stand-in: truncating signed divide, result pulse div_lat cycles after the request
    always @(posedge clk) begin
        div_valid_out <= 1'b0;
        if (reset) cnt <= 0;
        else if (div_valid_in) begin
            if (cnt != 0) overlap <= 1'b1;
            pulses <= pulses + 1;
            cnt    <= div_lat;
            q_hold <= (div_divisor == 0) ? 24'sd0 : div_dividend / div_divisor;
        end else if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                div_valid_out <= 1'b1;
                div_quotient  <= q_hold;
            end
        end
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask
    task automatic send(input int rho, input int theta);
        in_rho   = 11'(rho);
        in_theta = 8'(theta);
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask
    task automatic wait_out(output int c);
        c = 0;
        while (!out_valid && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    endtask
    task automatic run_peak(input string tag, input int rho, input int theta, input int e_slope,
                            input int e_int, input logic e_vert, input int e_pulses, output int c);
        int p;
        p = pulses;
        send(rho, theta);
        wait_out(c);
        check({tag, ".slope"}, out_slope, e_slope);
        check({tag, ".intercept"}, out_intercept, e_int);
        check({tag, ".vertical"}, {31'd0, out_vertical}, {31'd0, e_vert});
        check({tag, ".div_pulses"}, pulses - p, e_pulses);
        @(negedge clk);
        check({tag, ".done"}, {29'd0, out_valid, in_ready, out_vertical}, 32'b010);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rho = '0; in_theta = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.ctl", {29'd0, in_ready, out_valid, div_valid_in}, 32'b100);
        check("rst.slope", out_slope, 0);
        check("rst.intercept", out_intercept, 0);
        check("rst.vertical", {31'd0, out_vertical}, 0);
        check("rst.dividend", div_dividend, 0);
        check("rst.divisor", div_divisor, 0);
        reset = 1'b0;
        @(negedge clk);
        run_peak("t90", 100, 90, 0, 100, 1'b0, 2, cyc);
        div_lat = 5;
        run_peak("t45", 100, 45, -256, 141, 1'b0, 2, cyc);
        div_lat = 1;
        run_peak("t135", -50, 135, 256, -70, 1'b0, 2, cyc);
        run_peak("t0", 37, 0, 32'h7FFFFF, 37, 1'b1, 0, cyc);
        check("t0.latency", cyc, 1);
        out_ready = 1'b0;
        div_lat = 2;
        send(100, 45);
        wait_out(cyc);
        in_rho = 11'sd10; in_theta = 8'd200; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp.slope_hold", out_slope, -256);
            check("bp.intercept_hold", out_intercept, 141);
            check("bp.ctl", {30'd0, out_valid, in_ready}, 32'b10);
        end
        p0 = pulses;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp.release", {30'd0, out_valid, in_ready}, 32'b01);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.accepted", {31'd0, in_ready}, 0);
        wait_out(cyc);
        check("t200.slope", out_slope, 14563);
        check("t200.intercept", out_intercept, 568);
        check("t200.vertical", {31'd0, out_vertical}, 0);
        check("t200.div_pulses", pulses - p0, 2);
        @(negedge clk);
        div_lat = 6;
        p0 = pulses;
        send(100, 45);
        for (int n = 0; n < 200 && pulses != p0 + 2; n++) @(negedge clk);
        check("rst_mid.reached_wait_c", pulses - p0, 2);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid.idle", {29'd0, in_ready, out_valid, div_valid_in}, 32'b100);
        reset = 1'b0;
        div_lat = 3;
        run_peak("after_rst", 100, 90, 0, 100, 1'b0, 2, cyc);
        check("no_overlapping_requests", {31'd0, overlap}, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
